// File: rtl/oled_tx_arbiter_pkg.sv
// Shared types and constants for the OLED transfer arbiter.
// Data/command selector values match the sender's D/C pin.
package oled_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ACK
  } tx_state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int OLED_MAX_BYTES = 15;

endpackage

// File: rtl/oled_tx_arbiter_if.sv
// Requester and sender signals of the OLED transfer arbiter.
// slave: the arbiter; master: the surrounding requesters and sender.
interface oled_tx_arbiter_if #(
  parameter int MAX_BYTES = 15,
  parameter int CNT_W     = 4
);

  logic                   cmd_req;
  logic [CNT_W-1:0]       cmd_count;
  logic [8*MAX_BYTES-1:0] cmd_bytes;
  logic                   cmd_ack;

  logic                   pix_req;
  logic [CNT_W-1:0]       pix_count;
  logic [8*MAX_BYTES-1:0] pix_bytes;
  logic                   pix_ack;

  logic                   oled_start;
  logic                   oled_data_type;
  logic [CNT_W-1:0]       oled_byte_count;
  logic [8*MAX_BYTES-1:0] oled_bytes;
  logic                   oled_done;

  logic                   busy;
  logic                   timeout_err;

  modport slave (
    input  cmd_req, cmd_count, cmd_bytes,
    input  pix_req, pix_count, pix_bytes,
    input  oled_done,
    output cmd_ack, pix_ack,
    output oled_start, oled_data_type,
    output oled_byte_count, oled_bytes,
    output busy, timeout_err
  );

  modport master (
    output cmd_req, cmd_count, cmd_bytes,
    output pix_req, pix_count, pix_bytes,
    output oled_done,
    input  cmd_ack, pix_ack,
    input  oled_start, oled_data_type,
    input  oled_byte_count, oled_bytes,
    input  busy, timeout_err
  );

endinterface

// File: rtl/oled_tx_arbiter_rr_arb2.sv
// Two-way round-robin grant with a registered last-served bit.
// last_b resets to 1 so input a wins the first tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  input  logic served_b,
  output logic grant_any,
  output logic grant_b
);

  logic last_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (update) begin
      last_b <= served_b;
    end
  end

  always_comb begin
    grant_any = req_a | req_b;
    grant_b   = req_b;
    if (req_a && req_b) begin
      grant_b = ~last_b;
    end
  end

endmodule

// File: rtl/oled_tx_arbiter.sv
// Shares one OLED SPI byte-sender between a command and a pixel stream,
// one latched transfer at a time, with a per-transfer watchdog.
module oled_tx_arbiter
  import oled_pkg::*;
#(
  parameter int MAX_BYTES      = OLED_MAX_BYTES,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  oled_tx_arbiter_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(MAX_BYTES);

  tx_state_t state, nxt;

  logic [WD_W-1:0]        wd;
  logic                   cur_pix;
  logic                   start_q;
  logic                   cmd_ack_q;
  logic                   pix_ack_q;
  logic                   busy_q;
  logic                   err_q;
  logic                   dc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [8*MAX_BYTES-1:0] bytes_q;

  logic                   gnt_any;
  logic                   gnt_pix;
  logic                   grant;
  logic                   arb_upd;
  logic                   to_set;
  logic                   ack_pix;
  logic [CNT_W-1:0]       sel_cnt;
  logic [CNT_W-1:0]       clamped;
  logic [8*MAX_BYTES-1:0] sel_bytes;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_a     (bus.cmd_req),
    .req_b     (bus.pix_req),
    .update    (arb_upd),
    .served_b  (cur_pix),
    .grant_any (gnt_any),
    .grant_b   (gnt_pix)
  );

  always_comb begin
    sel_cnt   = gnt_pix ? bus.pix_count : bus.cmd_count;
    sel_bytes = gnt_pix ? bus.pix_bytes : bus.cmd_bytes;
    clamped   = (sel_cnt > MAX_CNT) ? MAX_CNT : sel_cnt;
  end

  always_comb begin
    nxt     = state;
    grant   = 1'b0;
    arb_upd = 1'b0;
    to_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          grant = 1'b1;
          nxt   = (clamped == '0) ? ACK : LAUNCH;
        end
      end
      LAUNCH: nxt = WAIT;
      WAIT: begin
        // done beats a simultaneous watchdog expiry
        if (bus.oled_done) begin
          nxt = ACK;
        end else if (wd == WD_LAST) begin
          to_set = 1'b1;
          nxt    = ACK;
        end
      end
      ACK: begin
        arb_upd = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
    ack_pix = grant ? gnt_pix : cur_pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wd        <= '0;
      cur_pix   <= 1'b0;
      start_q   <= 1'b0;
      cmd_ack_q <= 1'b0;
      pix_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      dc_q      <= 1'b0;
      cnt_q     <= '0;
      bytes_q   <= '0;
    end else begin
      state     <= nxt;
      start_q   <= (nxt == LAUNCH);
      busy_q    <= (nxt != IDLE);
      cmd_ack_q <= (nxt == ACK) && !ack_pix;
      pix_ack_q <= (nxt == ACK) && ack_pix;
      if (state == LAUNCH) begin
        wd <= '0;
      end else if (state == WAIT && !bus.oled_done
                   && wd != WD_LAST) begin
        wd <= wd + WD_W'(1);
      end
      if (grant) begin
        cnt_q   <= clamped;
        bytes_q <= sel_bytes;
        dc_q    <= gnt_pix ? DC_DATA : DC_CMD;
        cur_pix <= gnt_pix;
      end
      if (to_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.oled_start      = start_q;
  assign bus.cmd_ack         = cmd_ack_q;
  assign bus.pix_ack         = pix_ack_q;
  assign bus.busy            = busy_q;
  assign bus.timeout_err     = err_q;
  assign bus.oled_data_type  = dc_q;
  assign bus.oled_byte_count = cnt_q;
  assign bus.oled_bytes      = bytes_q;

endmodule

// File: tb/tb_oled_tx_arbiter.sv
// Directed bench: a default instance for the long single command and a
// small one (8 bytes, 20-cycle watchdog) for the corner cases.
module tb_oled_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic got;
  logic seen;

  always #5 clk = ~clk;

  oled_tx_arbiter_if #(.MAX_BYTES(15), .CNT_W(4)) ifa ();
  oled_tx_arbiter_if #(.MAX_BYTES(8),  .CNT_W(4)) ifs ();

  oled_tx_arbiter dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  oled_tx_arbiter #(
    .MAX_BYTES      (8),
    .CNT_W          (4),
    .TIMEOUT_CYCLES (20)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (ifs.slave)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ifa.cmd_req = 0; ifa.cmd_count = 0; ifa.cmd_bytes = '0;
    ifa.pix_req = 0; ifa.pix_count = 0; ifa.pix_bytes = '0;
    ifa.oled_done = 0;
    ifs.cmd_req = 0; ifs.cmd_count = 0; ifs.cmd_bytes = '0;
    ifs.pix_req = 0; ifs.pix_count = 0; ifs.pix_bytes = '0;
    ifs.oled_done = 0;

    // reset state
    step; step;
    check("rst_busy",  ifa.busy, 0);
    check("rst_start", ifa.oled_start, 0);
    check("rst_ack",   {ifa.cmd_ack, ifa.pix_ack}, 0);
    check("rst_cnt",   ifa.oled_byte_count, 0);
    check("rst_bytes", ifa.oled_bytes, 0);
    check("rst_err",   ifa.timeout_err, 0);
    check("rst_dc",    ifs.oled_data_type, 0);
    rst = 0;
    step;
    check("idle_busy", ifa.busy, 0);

    // single command, done 50 cycles after start
    ifa.cmd_req   = 1;
    ifa.cmd_count = 3;
    ifa.cmd_bytes = {8'hAF, 8'hA0, 8'h81, 96'h0};
    step;
    check("t1_start", ifa.oled_start, 1);
    check("t1_dc",    ifa.oled_data_type, 0);
    check("t1_cnt",   ifa.oled_byte_count, 3);
    check("t1_bytes", ifa.oled_bytes,
          {8'h0, 8'hAF, 8'hA0, 8'h81, 96'h0});
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step;
      if (ifa.cmd_ack || ifa.pix_ack || ifa.oled_start) seen = 1;
    end
    check("t1_quiet", seen, 0);
    ifa.oled_done = 1;
    step;
    check("t1_cmd_ack", ifa.cmd_ack, 1);
    check("t1_pix_ack", ifa.pix_ack, 0);
    ifa.oled_done = 0;
    ifa.cmd_req   = 0;
    step;
    check("t1_ack_end", ifa.cmd_ack, 0);
    check("t1_idle",    ifa.busy, 0);
    check("t1_hold",    ifa.oled_byte_count, 3);

    // contention: both held, done 10 cycles after each start
    ifs.cmd_req   = 1;
    ifs.cmd_count = 2;
    ifs.cmd_bytes = 64'hC0DE_0000_0000_0000;
    ifs.pix_req   = 1;
    ifs.pix_count = 5;
    ifs.pix_bytes = 64'h1122_3344_5500_0000;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        step;
        if (ifs.oled_start) got = 1;
      end
      check("c_start", got, 1);
      check("c_dc", ifs.oled_data_type, k % 2);
      check("c_cnt", ifs.oled_byte_count, (k % 2) ? 5 : 2);
      for (int i = 0; i < 10; i++) step;
      ifs.oled_done = 1;
      step;
      ifs.oled_done = 0;
      check("c_ack", {ifs.cmd_ack, ifs.pix_ack},
            (k % 2) ? 2'b01 : 2'b10);
      step;
      check("c_ack_once", {ifs.cmd_ack, ifs.pix_ack}, 0);
    end
    ifs.cmd_req = 0;
    ifs.pix_req = 0;
    step; step; step;
    check("c_idle", ifs.busy, 0);

    // zero-count pixel request
    ifs.pix_req   = 1;
    ifs.pix_count = 0;
    step;
    check("z_ack",   ifs.pix_ack, 1);
    check("z_start", ifs.oled_start, 0);
    check("z_dc",    ifs.oled_data_type, 1);
    check("z_cnt",   ifs.oled_byte_count, 0);
    ifs.pix_req = 0;
    step;
    check("z_no_start", ifs.oled_start, 0);
    check("z_idle",     ifs.busy, 0);

    // over-size count clamps to 8
    ifs.cmd_req   = 1;
    ifs.cmd_count = 12;
    ifs.cmd_bytes = 64'h0102_0304_0506_0708;
    step;
    check("o_start", ifs.oled_start, 1);
    check("o_cnt",   ifs.oled_byte_count, 8);
    check("o_bytes", ifs.oled_bytes, 64'h0102_0304_0506_0708);
    step;
    ifs.oled_done = 1;
    step;
    ifs.oled_done = 0;
    check("o_ack", ifs.cmd_ack, 1);
    ifs.cmd_req = 0;
    step;

    // watchdog: no done, ack 21 cycles after start
    ifs.cmd_req   = 1;
    ifs.cmd_count = 1;
    step;
    check("w_start", ifs.oled_start, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (ifs.cmd_ack || ifs.timeout_err) seen = 1;
    end
    check("w_early", seen, 0);
    step;
    check("w_ack", ifs.cmd_ack, 1);
    check("w_err", ifs.timeout_err, 1);
    ifs.cmd_req = 0;
    step;
    check("w_idle", ifs.busy, 0);
    check("w_sticky", ifs.timeout_err, 1);

    // normal transfer afterwards keeps the error flag
    ifs.cmd_req   = 1;
    ifs.cmd_count = 2;
    step;
    check("w2_start", ifs.oled_start, 1);
    step;
    ifs.oled_done = 1;
    step;
    ifs.oled_done = 0;
    check("w2_ack", ifs.cmd_ack, 1);
    check("w2_err", ifs.timeout_err, 1);
    ifs.cmd_req = 0;
    step;

    // async reset during a pixel transfer with a command pending
    ifs.pix_req   = 1;
    ifs.pix_count = 4;
    step;
    check("r_start", ifs.oled_start, 1);
    check("r_dc",    ifs.oled_data_type, 1);
    step; step;
    ifs.cmd_req   = 1;
    ifs.cmd_count = 3;
    #3;
    rst = 1;
    #1;
    check("r_busy",  ifs.busy, 0);
    check("r_err",   ifs.timeout_err, 0);
    check("r_cnt",   ifs.oled_byte_count, 0);
    check("r_dc0",   ifs.oled_data_type, 0);
    check("r_bytes", ifs.oled_bytes, 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (ifs.cmd_ack || ifs.pix_ack || ifs.busy) seen = 1;
    end
    check("r_no_ack", seen, 0);
    rst = 0;
    step;
    check("r2_start", ifs.oled_start, 1);
    check("r2_dc",    ifs.oled_data_type, 0);
    step;
    ifs.oled_done = 1;
    step;
    ifs.oled_done = 0;
    check("r2_ack", {ifs.cmd_ack, ifs.pix_ack}, 2'b10);
    ifs.cmd_req = 0;
    ifs.pix_req = 0;
    step;

    // done on the expiry cycle wins over the watchdog
    ifs.cmd_req   = 1;
    ifs.cmd_count = 1;
    step;
    check("e_start", ifs.oled_start, 1);
    seen = 0;
    for (int i = 0; i < 19; i++) begin
      step;
      if (ifs.cmd_ack) seen = 1;
    end
    step;
    ifs.oled_done = 1;
    check("e_early", seen, 0);
    step;
    ifs.oled_done = 0;
    check("e_ack", ifs.cmd_ack, 1);
    check("e_err", ifs.timeout_err, 0);
    ifs.cmd_req = 0;
    step;
    check("e_err_after", ifs.timeout_err, 0);
    check("e_idle", ifs.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_tx_arbiter.md
# oled_tx_arbiter

Shares the single OLED SPI byte-sender (`oled` controller) between two requesters: a command stream (init/config, D/C=0) and a pixel stream (image memory, D/C=1). It latches one request's payload, launches one transfer, waits for `spi_done`, acknowledges the requester and moves to the next. When both streams are pending, grants alternate; when only one is pending, it is served every time. A watchdog bounds each transfer.

## Interface
Parameters:
- `MAX_BYTES`, 15: maximum payload bytes per transfer.
- `CNT_W`, 4: width of byte-count fields.
- `TIMEOUT_CYCLES`, 1_000_000: cycles allowed in WAIT before abort.

Ports:
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `cmd_req` in 1: command request; held high until `cmd_ack`.
- `cmd_count` in CNT_W: command bytes to send.
- `cmd_bytes` in 8*MAX_BYTES: command payload, MSB byte sent first.
- `cmd_ack` out 1: one-cycle pulse when the command transfer completes.
- `pix_req`, `pix_count`, `pix_bytes`, `pix_ack`: same as above, for the pixel stream.
- `oled_start` out 1: one-cycle launch pulse to the sender.
- `oled_data_type` out 1: 0 = command, 1 = data.
- `oled_byte_count` out CNT_W: latched count.
- `oled_bytes` out 8*MAX_BYTES: latched payload.
- `oled_done` in 1: `spi_done` from the sender.
- `busy` out 1: high in any state except IDLE.
- `timeout_err` out 1: sticky; set on a watchdog abort, cleared only by `rst`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, ACK.
- **IDLE**
  - No request pending: stay in IDLE.
  - Exactly one request pending: grant it.
  - Both pending: grant the stream not served last. `last_pix` resets to 1, so a command wins the first tie.
  - On grant, latch the count, payload and data type, and record the granted stream.
  - Latched count 0: go directly to ACK; no `oled_start` is issued.
  - Otherwise go to LAUNCH.
- **Count clamp:** a count greater than MAX_BYTES is clamped to MAX_BYTES.
- **LAUNCH:** `oled_start`=1 for exactly this cycle; clear the watchdog; go to WAIT.
- **WAIT**
  - `oled_done`=1: go to ACK.
  - Otherwise the watchdog increments. On reaching TIMEOUT_CYCLES-1, set `timeout_err` and go to ACK.
  - If `oled_done` arrives in the same cycle as expiry, `oled_done` wins and `timeout_err` is not set.
- **ACK:** pulse the granted stream's ack for one cycle; update `last_pix`; go to IDLE.
- `oled_done` is ignored outside WAIT.
- Requester contract:
  - Payload must stay stable while `req` is high.
  - `req` drops on the edge at which the requester samples ack=1.
  - A `req` deassertion before ack is ignored: the transfer completes and the ack is still issued.
- `oled_byte_count`, `oled_bytes` and `oled_data_type` hold their latched values until the next grant.

## Timing
- Reset values: all outputs 0, state IDLE, watchdog 0, latched registers 0, `last_pix`=1.
- `rst` asserted mid-transfer aborts immediately; no ack is issued.
- Outputs are registered and there are no combinational paths from input to output.
- Request seen in IDLE at cycle N:
  - `oled_start` is high in cycle N+1.
  - `oled_done` seen in cycle M gives ack in cycle M+1 and IDLE in M+2.
  - The minimum turnaround between transfers is therefore 4 cycles plus the SPI time.
- Zero-count request at cycle N: ack in N+1.
- Back-to-back with both streams pending: the order is cmd, pix, cmd, pix, …

## Structure
- Shared package `oled_pkg`:
  - `typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ACK} tx_state_t`.
  - `DC_CMD=1'b0`, `DC_DATA=1'b1`.
  - `OLED_MAX_BYTES=15`.
- One sub-module, `rr_arb2`: a two-input round-robin grant with a registered last-served bit. Everything else (FSM, watchdog, latches) stays in `oled_tx_arbiter`.

## Test plan
- **Single command:** `cmd_req` with count 3, bytes 0xAF_A0_81…. Required: `oled_start` one cycle later with `oled_data_type`=0 and `oled_byte_count`=3; `oled_done` 50 cycles later gives `cmd_ack` the following cycle; `pix_ack` stays 0.
- **Contention:** `cmd_req` and `pix_req` held continuously with `oled_done` returned after 10 cycles. Required: grant sequence cmd, pix, cmd, pix, each followed by a single ack; `oled_data_type` toggles 0,1,0,1.
- **Zero and over-size count:** `pix_req` with count 0. Required: `pix_ack` next cycle with no `oled_start`. Then, with MAX_BYTES=8 and count 12, required: `oled_byte_count`=8.
- **Watchdog:** TIMEOUT_CYCLES=20 and `oled_done` never returned. Required: ack 21 cycles after start and `timeout_err`=1 sticky. A second transfer that completes normally leaves `timeout_err` at 1.
- **Done at expiry:** `oled_done` asserted exactly on the expiry cycle. Required: `timeout_err` stays 0 and ack is issued.
- **Async reset in WAIT:** assert `rst` between clock edges. Required: all outputs 0 immediately, no ack, and after release a pending `cmd_req` is granted first.
